fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction queue between the fetch stage and the control/decode stage. It captures each {PC, instruction} pair from the fetch stage and presents entries in order to decode through a valid/ready handshake. It absorbs decode stalls and discards all queued instructions on a taken branch or redirect flush. It decouples PC/fetch advance from decode back-pressure.

## Interface
Parameters:
- DEPTH, 4: entry count; power of two, ≥ 2
- XLEN, 32: PC and instruction width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- fetch_valid  input  1  fetch presents a new pair this cycle
- fetch_ready  output  1  queue accepts a pair this cycle
- fetch_pc  input  XLEN  PC of the presented instruction
- fetch_instruction  input  XLEN  instruction word from fetch
- dec_valid  output  1  head entry valid for decode
- dec_ready  input  1  decode consumes head this cycle
- dec_pc  output  XLEN  PC of head entry
- dec_instruction  output  XLEN  head instruction; NOP (32'h00000013) when dec_valid=0
- flush  input  1  discard all entries (branch taken / redirect)
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Push = fetch_valid && fetch_ready; pop = dec_valid && dec_ready.
- fetch_ready = (count < DEPTH) && !flush; depends only on state and flush, never on fetch_valid.
- dec_valid = (count != 0) && !flush.
- Storage is a circular buffer. wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Push writes {fetch_pc, fetch_instruction} at wr_ptr and advances wr_ptr. Pop advances rd_ptr.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (count=DEPTH): fetch_ready=0. A pop that cycle frees the slot for the next cycle only; no same-cycle refill.
- Empty (count=0): dec_valid=0, dec_pc=0, dec_instruction=NOP. A push becomes visible next cycle (default build).
- Flush: wr_ptr, rd_ptr and count go to 0 on the next edge. A push or pop in the flush cycle is suppressed because both readies/valids are forced low. Storage contents are not cleared.
- Reset mid-operation: all state cleared immediately (asynchronous), regardless of handshake in progress.
- Order is strictly FIFO. Entries are never dropped except by flush or reset.

## Timing
- Reset values: fetch_ready=1, dec_valid=0, dec_pc=0, dec_instruction=32'h00000013, count=0. Pointers=0. Storage=0.
- Latency push→dec_valid: 1 cycle (default); 0 cycles with bypass (see Configuration).
- Throughput: 1 push and 1 pop per cycle when 0 < count < DEPTH.
- After flush: fetch_ready=1 and dec_valid=0 on the cycle after the flush edge.
- dec_pc and dec_instruction are stable while dec_valid=1 and dec_ready=0.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count=0 and fetch_valid=1 (no flush), dec_valid=1 and dec_pc/dec_instruction come combinationally from the fetch inputs.
  - If dec_ready=1 the same cycle, the pair is consumed without being written; count stays 0.
  - If dec_ready=0, the pair is written normally.
- Undefined: no combinational fetch→decode path; minimum latency 1 cycle.

## Structure
- Shared package (cpu_pkg):
  - XLEN
  - NOP_INSTR = 32'h00000013
  - fetch_entry_t typedef {pc, instruction}
- One sub-module: fetch_queue_storage. DEPTH×fetch_entry_t register array with one write port (we, waddr, wdata) and one asynchronous read port. Reset clears it.
- Pointer, count, handshake and bypass logic live in fetch_queue.

## Test plan
- Reset: hold Reset=0 mid-stream with count=3 → count=0, dec_valid=0, dec_instruction=32'h00000013 immediately; fetch_ready=1 after release.
- Fill: push PCs 0,4,8,12 with instructions 32'h00000533, 32'h00100593, 32'h021081B3, 32'h00000013 and dec_ready=0 → count=4, fetch_ready=0; a 5th push is not accepted.
- Drain order: from full, dec_ready=1 for 4 cycles → dec_pc sequence 0,4,8,12 with matching instructions; then count=0 and dec_valid=0.
- Wrap and simultaneous: steady push+pop for 10 cycles at count=2 → count stays 2; PCs emerge in order across pointer wrap.
- Flush: count=3, assert flush together with fetch_valid=1 and dec_ready=1 → next cycle count=0; no entry consumed or written that cycle.
- Bypass (macro defined): count=0, fetch_valid=1, fetch_pc=16, dec_ready=1 → same-cycle dec_valid=1, dec_pc=16; count remains 0. Without macro: dec_valid=0 that cycle, dec_valid=1 the next.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide types and constants.
//   XLEN          - PC and instruction width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0)
//   fetch_entry_t - {pc, instruction} pair carried from fetch to decode
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// fetch_queue_storage: DEPTH x fetch_entry_t register array.
// One synchronous write port, one asynchronous (combinational) read port.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset (clears every entry)
//   we_i          - write enable
//   waddr_i       - write address
//   wdata_i       - entry written on the rising edge when we_i=1
//   raddr_i       - read address
//   rdata_o       - entry at raddr_i
module fetch_queue_storage
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  fetch_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fetch_entry_t rdata_o
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction queue between fetch and decode.
// Captures {pc, instruction} pairs from fetch and hands them to decode over a
// valid/ready handshake; a flush discards every queued entry.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN - when the queue is empty the
// incoming fetch pair is presented to decode combinationally in the same cycle.
// Parameters:
//   DEPTH - entry count (power of two, >= 2)
//   XLEN  - PC/instruction width (must equal cpu_pkg::XLEN)
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   fetch_valid_i/ready_o, fetch_pc_i, fetch_instruction_i - fetch side
//   dec_valid_o/ready_i, dec_pc_o, dec_instruction_o       - decode side
//   flush_i              - drop all entries on the next edge
//   count_o              - current occupancy
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = cpu_pkg::XLEN,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic [XLEN-1:0] fetch_instruction_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [XLEN-1:0] dec_instruction_o,
    input  logic            flush_i,
    output logic [CW-1:0]   count_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic         empty, full, bypass, push, pop;
    fetch_entry_t wr_entry, rd_entry, head;

    assign wr_entry = '{pc: fetch_pc_i, instruction: fetch_instruction_i};

    fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = empty && fetch_valid_i && !flush_i;
`else
        bypass = 1'b0;
`endif

        // Readies/valids are forced low during flush so nothing moves that cycle.
        fetch_ready_o = !full && !flush_i;
        dec_valid_o   = (!empty || bypass) && !flush_i;

        head              = bypass ? wr_entry : rd_entry;
        dec_pc_o          = dec_valid_o ? head.pc : '0;
        dec_instruction_o = dec_valid_o ? head.instruction : NOP_INSTR;

        // A bypassed pair taken by decode the same cycle never enters storage.
        push = fetch_valid_i && fetch_ready_o && !(bypass && dec_ready_i);
        pop  = dec_valid_o && dec_ready_i && !bypass;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            fetch_valid_i;
    logic            fetch_ready_o;
    logic [XLEN-1:0] fetch_pc_i;
    logic [XLEN-1:0] fetch_instruction_i;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [XLEN-1:0] dec_pc_o;
    logic [XLEN-1:0] dec_instruction_o;
    logic            flush_i;
    logic [CW-1:0]   count_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] instr_tbl [4];

    fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .fetch_valid_i       (fetch_valid_i),
        .fetch_ready_o       (fetch_ready_o),
        .fetch_pc_i          (fetch_pc_i),
        .fetch_instruction_i (fetch_instruction_i),
        .dec_valid_o         (dec_valid_o),
        .dec_ready_i         (dec_ready_i),
        .dec_pc_o            (dec_pc_o),
        .dec_instruction_o   (dec_instruction_o),
        .flush_i             (flush_i),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        fetch_valid_i       = 1'b1;
        fetch_pc_i          = pc;
        fetch_instruction_i = instr;
        tick();
        fetch_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        fetch_valid_i = 1'b0; fetch_pc_i = '0; fetch_instruction_i = '0;
        dec_ready_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        vec_cnt++; if (count_o !== 3'd0) begin err_cnt++;
            $display("FAIL reset_count got=%0d exp=0", count_o); end
        vec_cnt++; if (fetch_ready_o !== 1'b1) begin err_cnt++;
            $display("FAIL reset_fetch_ready got=%b exp=1", fetch_ready_o); end
        vec_cnt++; if (dec_valid_o !== 1'b0) begin err_cnt++;
            $display("FAIL reset_dec_valid got=%b exp=0", dec_valid_o); end
        vec_cnt++; if (dec_pc_o !== 32'h0) begin err_cnt++;
            $display("FAIL reset_dec_pc got=%h exp=0", dec_pc_o); end
        vec_cnt++; if (dec_instruction_o !== NOP) begin err_cnt++;
            $display("FAIL reset_dec_instr got=%h exp=%h", dec_instruction_o, NOP); end
        tick();
    endtask

    task automatic test_fill();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'(4 * i), instr_tbl[i]);
        vec_cnt++; if (count_o !== 3'd4) begin err_cnt++;
            $display("FAIL fill_count got=%0d exp=4", count_o); end
        vec_cnt++; if (fetch_ready_o !== 1'b0) begin err_cnt++;
            $display("FAIL fill_fetch_ready got=%b exp=0", fetch_ready_o); end
        // Stalled head must hold the first entry.
        vec_cnt++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'd0) begin err_cnt++;
            $display("FAIL fill_head got valid=%b pc=%h exp valid=1 pc=0", dec_valid_o, dec_pc_o); end
        // Fifth push must be refused.
        push_one(32'd16, 32'hdead_beef);
        vec_cnt++; if (count_o !== 3'd4) begin err_cnt++;
            $display("FAIL fill_overflow_count got=%0d exp=4", count_o); end
        vec_cnt++; if (dec_pc_o !== 32'd0 || dec_instruction_o !== instr_tbl[0]) begin err_cnt++;
            $display("FAIL fill_stall_stable got pc=%h instr=%h exp pc=0 instr=%h",
                     dec_pc_o, dec_instruction_o, instr_tbl[0]); end
    endtask

    task automatic test_drain();
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'(4 * i) ||
                dec_instruction_o !== instr_tbl[i]) begin
                err_cnt++;
                $display("FAIL drain_%0d got valid=%b pc=%h instr=%h exp valid=1 pc=%h instr=%h",
                         i, dec_valid_o, dec_pc_o, dec_instruction_o, 32'(4 * i), instr_tbl[i]);
            end
            tick();
        end
        dec_ready_i = 1'b0;
        #1;
        vec_cnt++; if (count_o !== 3'd0 || dec_valid_o !== 1'b0 || dec_instruction_o !== NOP)
        begin err_cnt++;
            $display("FAIL drain_empty got count=%0d valid=%b instr=%h exp count=0 valid=0 instr=%h",
                     count_o, dec_valid_o, dec_instruction_o, NOP); end
    endtask

    task automatic test_wrap();
        push_one(32'd100, 32'h1000_0000);
        push_one(32'd104, 32'h1000_0001);
        dec_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fetch_valid_i       = 1'b1;
            fetch_pc_i          = 32'(108 + 4 * i);
            fetch_instruction_i = 32'h1000_0002 + 32'(i);
            #1;
            vec_cnt++;
            if (dec_pc_o !== 32'(100 + 4 * i) || dec_instruction_o !== 32'h1000_0000 + 32'(i))
            begin
                err_cnt++;
                $display("FAIL wrap_pc_%0d got pc=%h instr=%h exp pc=%h instr=%h", i, dec_pc_o,
                         dec_instruction_o, 32'(100 + 4 * i), 32'h1000_0000 + 32'(i));
            end
            tick();
            vec_cnt++; if (count_o !== 3'd2) begin err_cnt++;
                $display("FAIL wrap_count_%0d got=%0d exp=2", i, count_o); end
        end
        fetch_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vec_cnt++; if (dec_pc_o !== 32'(140 + 4 * i)) begin err_cnt++;
                $display("FAIL wrap_tail_%0d got=%h exp=%h", i, dec_pc_o, 32'(140 + 4 * i)); end
            tick();
        end
        dec_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        dec_ready_i = 1'b0;
        push_one(32'd200, 32'h2000_0000);
        push_one(32'd204, 32'h2000_0001);
        push_one(32'd208, 32'h2000_0002);
        vec_cnt++; if (count_o !== 3'd3) begin err_cnt++;
            $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
        flush_i = 1'b1; fetch_valid_i = 1'b1; fetch_pc_i = 32'd300;
        fetch_instruction_i = 32'h3000_0000; dec_ready_i = 1'b1;
        #1;
        vec_cnt++; if (fetch_ready_o !== 1'b0 || dec_valid_o !== 1'b0) begin err_cnt++;
            $display("FAIL flush_handshake got ready=%b valid=%b exp 0 0",
                     fetch_ready_o, dec_valid_o); end
        tick();
        flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
        #1;
        vec_cnt++;
        if (count_o !== 3'd0 || fetch_ready_o !== 1'b1 || dec_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_post got count=%0d ready=%b valid=%b exp 0 1 0",
                     count_o, fetch_ready_o, dec_valid_o);
        end
        push_one(32'd400, 32'h4000_0000);
        vec_cnt++; if (dec_pc_o !== 32'd400 || count_o !== 3'd1) begin err_cnt++;
            $display("FAIL flush_refill got pc=%h count=%0d exp pc=190 count=1", dec_pc_o, count_o); end
        dec_ready_i = 1'b1;
        tick();
        dec_ready_i = 1'b0;
    endtask

    task automatic test_bypass();
        fetch_valid_i = 1'b1; fetch_pc_i = 32'd16;
        fetch_instruction_i = 32'h00a0_0093; dec_ready_i = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        vec_cnt++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'd16) begin err_cnt++;
            $display("FAIL bypass_same_cycle got valid=%b pc=%h exp valid=1 pc=10",
                     dec_valid_o, dec_pc_o); end
        tick();
        fetch_valid_i = 1'b0;
        vec_cnt++; if (count_o !== 3'd0) begin err_cnt++;
            $display("FAIL bypass_count got=%0d exp=0", count_o); end
`else
        vec_cnt++; if (dec_valid_o !== 1'b0) begin err_cnt++;
            $display("FAIL nobypass_same_cycle got valid=%b exp=0", dec_valid_o); end
        tick();
        fetch_valid_i = 1'b0;
        #1;
        vec_cnt++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'd16 || dec_instruction_o !== 32'h00a0_0093)
        begin
            err_cnt++;
            $display("FAIL nobypass_next got valid=%b pc=%h instr=%h exp valid=1 pc=10 instr=00a00093",
                     dec_valid_o, dec_pc_o, dec_instruction_o);
        end
        tick();
`endif
        dec_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        dec_ready_i = 1'b0;
        push_one(32'd500, 32'h5000_0000);
        push_one(32'd504, 32'h5000_0001);
        push_one(32'd508, 32'h5000_0002);
        fetch_valid_i = 1'b1; fetch_pc_i = 32'd512; dec_ready_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        vec_cnt++;
        if (count_o !== 3'd0 || dec_valid_o !== 1'b0 || dec_instruction_o !== NOP) begin
            err_cnt++;
            $display("FAIL reset_mid got count=%0d valid=%b instr=%h exp 0 0 %h",
                     count_o, dec_valid_o, dec_instruction_o, NOP);
        end
        fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        vec_cnt++; if (fetch_ready_o !== 1'b1 || count_o !== 3'd0) begin err_cnt++;
            $display("FAIL reset_release got ready=%b count=%0d exp 1 0", fetch_ready_o, count_o); end
    endtask

    initial begin
        instr_tbl[0] = 32'h0000_0533;
        instr_tbl[1] = 32'h0010_0593;
        instr_tbl[2] = 32'h0210_81B3;
        instr_tbl[3] = 32'h0000_0013;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
